// File: rtl/axis_tg_pkg.sv
// axis_tg_pkg: shared states, payload layout, dest modes and LFSR constants for axis_traffic_gen
package axis_tg_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} tg_state_e;
  localparam int BEAT_LSB = 0;
  localparam int SEQ_LSB = 16;
  localparam int SRC_LSB = 32;
  localparam int DEST_LSB = 40;
  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_RR = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], ^(x & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/axis_traffic_gen_if.sv
// axis_traffic_gen_if: AXI-Stream bundle (tvalid/tready/tdata/tlast/tdest) with master/slave views
interface axis_traffic_gen_if #(
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TDEST_WIDTH-1:0] tdest;
  modport master(output tvalid, tdata, tlast, tdest, input tready);
  modport slave(input tvalid, tdata, tlast, tdest, output tready);
endinterface

// File: rtl/axis_tg_lfsr.sv
// axis_tg_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11); load_i reseeds, step_i advances, both = seed then step; q_o = low W bits
module axis_tg_lfsr
  import axis_tg_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  output logic [W-1:0] q_o
);
  logic [15:0] q_q, q_d, s;
  always_comb begin
    s = load_i ? LFSR_SEED : q_q;
    q_d = step_i ? lfsr_next(s) : s;
  end
  always_ff @(posedge clk) begin
    if (rst) q_q <= LFSR_SEED;
    else q_q <= q_d;
  end
  assign q_o = q_q[W-1:0];
endmodule

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: programmable AXIS packet source; start latches cfg_*, emits cfg_num_pkts packets on axis_out (master), reports busy/done/pkts_sent
module axis_traffic_gen
  import axis_tg_pkg::*;
#(
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int SRC_ID = 0,
  parameter int NUM_DESTS = 10,
  parameter int LEN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            cfg_num_pkts,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic [1:0]             cfg_dest_mode,
  input  logic [TDEST_WIDTH-1:0] cfg_fixed_dest,
  input  logic [7:0]             cfg_gap,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkts_sent,
  axis_traffic_gen_if.master     axis_out
);
  localparam logic [TDEST_WIDTH:0] NDW = (TDEST_WIDTH+1)'(NUM_DESTS);
  localparam logic [TDEST_WIDTH-1:0] SEED_LO = LFSR_SEED[TDEST_WIDTH-1:0];
  localparam logic [7:0] SRC = 8'(SRC_ID);
  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
  tg_state_e state_q, state_d;
  logic [15:0] num_q, num_d, seq_q, seq_d, pkts_q, pkts_d, seq_n;
  logic [LEN_WIDTH-1:0] len_q, len_d, beat_q, beat_d, len_s;
  logic [1:0] mode_q, mode_d, mode_s;
  logic [TDEST_WIDTH-1:0] fixed_q, fixed_d, rr_q, rr_d, tdest_q, tdest_d, fixed_s, rr_s, lf_s, lf_o, dsel;
  logic [7:0] gap_q, gap_d, gcnt_q, gcnt_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, done_q, ld, first, adv;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  function automatic logic [TDATA_WIDTH-1:0] pay(input logic [15:0] b, input logic [15:0] s,
                                                 input logic [TDEST_WIDTH-1:0] d);
    pay = '0;
    pay[BEAT_LSB+:16] = b;
    pay[SEQ_LSB+:16] = s;
    pay[SRC_LSB+:8] = SRC;
    pay[DEST_LSB+:TDEST_WIDTH] = d;
  endfunction
  axis_tg_lfsr #(.W(TDEST_WIDTH)) u_lfsr (
    .clk(clk), .rst(rst), .load_i(first), .step_i(ld), .q_o(lf_o)
  );
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    len_d = len_q;
    mode_d = mode_q;
    fixed_d = fixed_q;
    gap_d = gap_q;
    gcnt_d = gcnt_q;
    beat_d = beat_q;
    seq_d = seq_q;
    rr_d = rr_q;
    pkts_d = pkts_q;
    tvalid_d = tvalid_q;
    tlast_d = tlast_q;
    tdata_d = tdata_q;
    tdest_d = tdest_q;
    ld = 1'b0;
    first = 1'b0;
    adv = 1'b0;
    seq_n = seq_q + 16'd1;
    case (state_q)
      S_IDLE: if (start) begin
        num_d = cfg_num_pkts;
        len_d = cfg_pkt_len == '0 ? ONE : cfg_pkt_len;
        mode_d = cfg_dest_mode;
        fixed_d = cfg_fixed_dest;
        gap_d = cfg_gap;
        pkts_d = '0;
        rr_d = '0;
        first = 1'b1;
        seq_n = '0;
        ld = cfg_num_pkts != '0;
        state_d = cfg_num_pkts == '0 ? S_FIN : S_SEND;
      end
      S_SEND: if (tvalid_q && axis_out.tready) begin
        if (!tlast_q) adv = 1'b1;
        else begin
          pkts_d = pkts_q + 16'd1;
          if (pkts_d == num_q || gap_q != '0) begin
            state_d = pkts_d == num_q ? S_FIN : S_GAP;
            gcnt_d = gap_q - 8'd1;
            tvalid_d = 1'b0;
            tlast_d = 1'b0;
          end else ld = 1'b1;
        end
      end
      S_GAP: if (gcnt_q == '0) begin
        state_d = S_SEND;
        ld = 1'b1;
      end else gcnt_d = gcnt_q - 8'd1;
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // On the start cycle the latched config/seed are not yet visible, so source them directly
    mode_s = first ? cfg_dest_mode : mode_q;
    fixed_s = first ? cfg_fixed_dest : fixed_q;
    len_s = first ? len_d : len_q;
    rr_s = first ? '0 : rr_q;
    lf_s = first ? SEED_LO : lf_o;
    dsel = mode_s == MODE_RR ? rr_s :
           mode_s == MODE_LFSR ? ({1'b0, lf_s} >= NDW ? lf_s - NDW[TDEST_WIDTH-1:0] : lf_s) : fixed_s;
    if (ld) begin
      beat_d = '0;
      seq_d = seq_n;
      tdest_d = dsel;
      tvalid_d = 1'b1;
      tlast_d = len_s == ONE;
      tdata_d = pay(16'd0, seq_n, dsel);
      rr_d = {1'b0, rr_s} == NDW - 1'b1 ? '0 : rr_s + 1'b1;
    end
    if (adv) begin
      beat_d = beat_q + ONE;
      tlast_d = beat_d == len_q - ONE;
      tdata_d = pay(16'(beat_d), seq_q, tdest_q);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q <= '0;
      len_q <= '0;
      mode_q <= '0;
      fixed_q <= '0;
      gap_q <= '0;
      gcnt_q <= '0;
      beat_q <= '0;
      seq_q <= '0;
      rr_q <= '0;
      pkts_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
      tdest_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      len_q <= len_d;
      mode_q <= mode_d;
      fixed_q <= fixed_d;
      gap_q <= gap_d;
      gcnt_q <= gcnt_d;
      beat_q <= beat_d;
      seq_q <= seq_d;
      rr_q <= rr_d;
      pkts_q <= pkts_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tdata_q <= tdata_d;
      tdest_q <= tdest_d;
      busy_q <= state_d == S_SEND || state_d == S_GAP;
      done_q <= state_d == S_FIN;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign pkts_sent = pkts_q;
  assign axis_out.tvalid = tvalid_q;
  assign axis_out.tlast = tlast_q;
  assign axis_out.tdata = tdata_q;
  assign axis_out.tdest = tdest_q;
endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb_axis_traffic_gen: randomized and directed checks of axis_traffic_gen against a packet-list model
module tb_axis_traffic_gen;
  localparam int TW = 4, DW = 64, SRC = 3, ND = 10, LW = 8;
  typedef struct {logic [63:0] d; logic l; logic [3:0] t;} beat_t;
  logic clk = 0, rst = 1, start = 0, busy, done, rnd = 0;
  logic [15:0] cfg_num_pkts = 0, pkts_sent;
  logic [LW-1:0] cfg_pkt_len = 0;
  logic [1:0] cfg_dest_mode = 0;
  logic [TW-1:0] cfg_fixed_dest = 0;
  logic [7:0] cfg_gap = 0;
  int nvec = 0, nerr = 0, cyc = 0, done_n = 0, done_cyc = 0, st_cyc = 0;
  beat_t exp_q[$];
  int hs_cyc[$];
  logic [63:0] hs_data[$];
  int hs_dest[$];
  int saved[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  axis_traffic_gen_if #(.TDEST_WIDTH(TW), .TDATA_WIDTH(DW)) axis_out();
  axis_traffic_gen #(.TDEST_WIDTH(TW), .TDATA_WIDTH(DW), .SRC_ID(SRC), .NUM_DESTS(ND), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_pkts(cfg_num_pkts), .cfg_pkt_len(cfg_pkt_len),
    .cfg_dest_mode(cfg_dest_mode), .cfg_fixed_dest(cfg_fixed_dest), .cfg_gap(cfg_gap),
    .busy(busy), .done(done), .pkts_sent(pkts_sent), .axis_out(axis_out)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic build(input int n, input int len, input int mode, input int fx);
    int L, rr, lf, d;
    L = len == 0 ? 1 : len;
    rr = 0;
    lf = 'hACE1;
    for (int p = 0; p < n; p++) begin
      if (mode == 1) begin
        d = rr;
        rr = (rr + 1) % ND;
      end else if (mode == 2) begin
        d = lf % 16;
        if (d >= ND) d -= ND;
        lf = ((lf << 1) | (((lf >> 15) ^ (lf >> 13) ^ (lf >> 12) ^ (lf >> 10)) & 1)) & 'hFFFF;
      end else d = fx;
      for (int b = 0; b < L; b++)
        exp_q.push_back('{d: (64'(d) << 40) | (64'(SRC) << 32) | (64'(p) << 16) | 64'(b), l: b == L - 1, t: 4'(d)});
    end
  endtask
  task automatic kick(input int n, input int len, input int mode, input int fx, input int gap);
    build(n, len, mode, fx);
    hs_cyc.delete();
    hs_data.delete();
    hs_dest.delete();
    cfg_num_pkts = 16'(n);
    cfg_pkt_len = LW'(len);
    cfg_dest_mode = 2'(mode);
    cfg_fixed_dest = TW'(fx);
    cfg_gap = 8'(gap);
    start = 1;
    st_cyc = cyc + 1;
    tick();
    start = 0;
  endtask
  task automatic finish_run(input int n);
    int t0, i;
    t0 = done_n;
    for (i = 0; i < 3000 && done_n == t0; i++) @(posedge clk);
    #1;
    if (done_n == t0) chk("timeout", 0, 1);
    tick();
    tick();
    chk("done_pulse", done_n, t0 + 1);
    chk("busy_end", busy, 0);
    chk("pkts_sent", pkts_sent, n);
    chk("drain", exp_q.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    axis_out.tready = rnd ? 1'($urandom % 2) : 1'b1;
  end
  initial begin
    beat_t e;
    logic stall;
    logic [63:0] pd;
    logic pl;
    logic [3:0] pt;
    stall = 0;
    forever begin
      @(negedge clk);
      if (rst) stall = 0;
      else begin
        if (stall) begin
          chk("hold_valid", axis_out.tvalid, 1);
          chk("hold_data", axis_out.tdata, pd);
          chk("hold_last", axis_out.tlast, pl);
          chk("hold_dest", axis_out.tdest, pt);
        end
        if (axis_out.tvalid && axis_out.tready) begin
          if (exp_q.size() == 0) chk("extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("tdata", axis_out.tdata, e.d);
            chk("tlast", axis_out.tlast, e.l);
            chk("tdest", axis_out.tdest, e.t);
          end
          hs_cyc.push_back(cyc);
          hs_data.push_back(axis_out.tdata);
          hs_dest.push_back(int'(axis_out.tdest));
        end
        if (done) begin
          done_cyc = cyc;
          done_n++;
        end
        stall = axis_out.tvalid && !axis_out.tready;
        pd = axis_out.tdata;
        pl = axis_out.tlast;
        pt = axis_out.tdest;
      end
    end
  end
  initial begin
    int i;
    axis_out.tready = 1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkts", pkts_sent, 0);
    chk("rst_tvalid", axis_out.tvalid, 0);
    chk("rst_tdata", axis_out.tdata, 0);
    rst = 0;
    tick();
    kick(3, 4, 0, 5, 0);
    finish_run(3);
    chk("t1_first_cyc", hs_cyc[0], st_cyc);
    chk("t1_contig", hs_cyc[11] - hs_cyc[0], 11);
    chk("t1_done_cyc", done_cyc, hs_cyc[11] + 1);
    chk("t1_beat0", hs_data[0], 64'h0503_0000_0000);
    chk("t1_beat11", hs_data[11], 64'h0503_0002_0003);
    kick(12, 1, 1, 0, 0);
    finish_run(12);
    chk("t2_dest9", hs_dest[9], 9);
    chk("t2_dest10", hs_dest[10], 0);
    chk("t2_dest11", hs_dest[11], 1);
    chk("t2_seq11", hs_data[11][31:16], 11);
    kick(2, 2, 0, 7, 3);
    finish_run(2);
    chk("t3_gap", hs_cyc[2] - hs_cyc[1], 4);
    chk("t3_no_tail_gap", done_cyc, hs_cyc[3] + 1);
    rnd = 1;
    kick(4, 5, 2, 0, 1);
    finish_run(4);
    chk("t4_lfsr0", hs_dest[0], 1);
    chk("t4_lfsr1", hs_dest[5], 3);
    chk("t4_lfsr2", hs_dest[10], 7);
    chk("t4_lfsr3", hs_dest[15], 5);
    saved = hs_dest;
    kick(4, 5, 2, 0, 1);
    finish_run(4);
    for (int k = 0; k < 20; k++) chk("t4_repeat", hs_dest[k], saved[k]);
    for (int k = 0; k < 8; k++) begin
      kick($urandom_range(1, 5), $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3));
      finish_run(int'(cfg_num_pkts));
      for (int j = 0; j < hs_dest.size(); j++) chk("rand_dest_range", hs_dest[j] < ND || cfg_dest_mode != 2, 1);
    end
    rnd = 0;
    kick(0, 3, 0, 1, 0);
    finish_run(0);
    chk("t5_done_cyc", done_cyc, st_cyc);
    chk("t5_no_beats", hs_cyc.size(), 0);
    kick(2, 3, 0, 4, 2);
    tick();
    tick();
    cfg_num_pkts = 7;
    cfg_pkt_len = 1;
    start = 1;
    tick();
    start = 0;
    finish_run(2);
    chk("t5_ignored_beats", hs_cyc.size(), 6);
    kick(2, 4, 0, 6, 0);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axis_out.tvalid && axis_out.tdata[15:0] == 16'd2) break;
    end
    if (i == 100) chk("t6_reach_beat2", 0, 1);
    #1;
    rst = 1;
    tick();
    chk("t6_tvalid", axis_out.tvalid, 0);
    chk("t6_tlast", axis_out.tlast, 0);
    chk("t6_tdata", axis_out.tdata, 0);
    chk("t6_tdest", axis_out.tdest, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_pkts", pkts_sent, 0);
    rst = 0;
    exp_q.delete();
    tick();
    kick(2, 2, 2, 0, 0);
    finish_run(2);
    chk("t6_seq0", hs_data[0][31:16], 0);
    chk("t6_seq1", hs_data[2][31:16], 1);
    chk("t6_lfsr_reseed", hs_dest[0], 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
